freq_window_check: RTL

FREQ_WINDOW_CHECK -- requirements
Module: freq_window_check

---
 rtl/freq_window_check.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/freq_window_check.sv
// Frequency window checker: resets an upstream counter, waits for its result,
// double-samples the cross-domain count until stable and classifies it.
module freq_window_check #(
  parameter logic [31:0] MIN_COUNT     = 32'd9_900_000,
  parameter logic [31:0] MAX_COUNT     = 32'd10_100_000,
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [31:0] TIMEOUT       = 32'd25_000_000
) (
  input  logic        ref_clock,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  output logic        meas_reset_n,
  input  logic        meas_done,
  input  logic [31:0] meas_value,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result_count,
  output logic        in_range,
  output logic        too_slow,
  output logic        too_fast,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_RUN      = 3'd2,
    S_SETTLE   = 3'd3,
    S_SAMPLE_A = 3'd4,
    S_SAMPLE_B = 3'd5,
    S_REPORT   = 3'd6
  } state_e;

  localparam logic [31:0] CLEAR_LAST  = (CLEAR_CYCLES > 0)  ? 32'(CLEAR_CYCLES) - 32'd1  : 32'd0;
  localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES) - 32'd1 : 32'd0;
  localparam logic [3:0]  FLAG_TIMEOUT = 4'b1000;

  // Flag order everywhere: {timeout_err, too_fast, too_slow, in_range}.
  function automatic logic [3:0] classify(input logic [31:0] count);
    logic [3:0] f;
    if (count < MIN_COUNT) begin
      f = 4'b0010;
    end else if (count > MAX_COUNT) begin
      f = 4'b0100;
    end else begin
      f = 4'b0001;
    end
    return f;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic [2:0]  retry_q, retry_d;
  logic [31:0] sample_a_q, sample_a_d;
  logic [31:0] rep_count;
  logic [3:0]  rep_flags;

  logic        mrn_q, mrn_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [3:0]  flags_q, flags_d;

  // State and datapath registers.
  always_ff @(posedge ref_clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      retry_q    <= 3'd0;
      sample_a_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      sample_a_q <= sample_a_d;
    end
  end

  // Next-state logic; the shared phase counter is reused by CLEAR, RUN and SETTLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    sample_a_d = sample_a_q;
    rep_count  = 32'd0;
    rep_flags  = 4'b0000;
    cnt_inc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cnt_q >= CLEAR_LAST) begin
          state_d = S_RUN;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        if (meas_done) begin
          state_d = S_SETTLE;
          cnt_d   = 32'd0;
        end else if (cnt_inc >= TIMEOUT) begin
          state_d   = S_REPORT;
          rep_count = 32'd0;
          rep_flags = FLAG_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_d = S_SAMPLE_A;
          retry_d = 3'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SAMPLE_A: begin
        sample_a_d = meas_value;
        state_d    = S_SAMPLE_B;
      end
      S_SAMPLE_B: begin
        // Two equal consecutive samples mean the foreign-domain count is stable.
        if (meas_value == sample_a_q) begin
          state_d   = S_REPORT;
          rep_count = meas_value;
          rep_flags = classify(meas_value);
        end else if (retry_q == 3'd7) begin
          state_d   = S_REPORT;
          rep_count = meas_value;
          rep_flags = FLAG_TIMEOUT;
        end else begin
          retry_d = retry_q + 3'd1;
          state_d = S_SAMPLE_A;
        end
      end
      S_REPORT: begin
        cnt_d   = 32'd0;
        retry_d = 3'd0;
        if (continuous) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
        retry_d = 3'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    mrn_d   = !((state_d == S_IDLE) || (state_d == S_CLEAR));
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_REPORT);
    count_d = count_q;
    flags_d = flags_q;
    if (state_d == S_REPORT) begin
      count_d = rep_count;
      flags_d = rep_flags;
    end else begin
      count_d = count_q;
      flags_d = flags_q;
    end
  end

  // Output registers.
  always_ff @(posedge ref_clock or negedge reset) begin
    if (!reset) begin
      mrn_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
      flags_q <= 4'b0000;
    end else begin
      mrn_q   <= mrn_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign meas_reset_n = mrn_q;
  assign busy         = busy_q;
  assign valid        = valid_q;
  assign result_count = count_q;
  assign {timeout_err, too_fast, too_slow, in_range} = flags_q;

endmodule
